// File: rtl/plat_frame_ctrl.sv
// plat_frame_ctrl: per-frame sequencer for the platform block.
// Each frame pulse runs the platform req/ack handshake, then delivers at
// most one queued gadget effect from a small FIFO, so gadgets caught close
// together are applied one per frame.
// Optional feature macro: PLAT_FRAME_ACK_TIMEOUT_EN (abandon REQ after
// ACK_TIMEOUT cycles without ack and flag o_err[2]).
module plat_frame_ctrl #(
    parameter int FIFO_DEPTH     = 4,
    parameter int ACK_TIMEOUT    = 15,
    parameter int GADGET_BIT_CNT = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_game_start,
    input  logic                      i_cal_frame,
    input  logic                      i_gadget_valid,
    input  logic [GADGET_BIT_CNT-1:0] i_gadget_effect,
    output logic                      o_fifo_full,
    output logic                      o_plat_req,
    input  logic                      i_plat_ack,
    output logic [GADGET_BIT_CNT-1:0] o_plat_gadget_effect,
    output logic                      o_plat_receive_gadget,
    output logic                      o_frame_done,
    output logic                      o_busy,
    output logic [2:0]                o_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DISP} state_t;

    state_t                    state_q, state_d;
    logic                      req_q, req_d;
    logic                      strobe_q, strobe_d;
    logic                      done_q, done_d;
    logic                      busy_q;
    logic                      full_q;
    logic [2:0]                err_q, err_d;
    logic [GADGET_BIT_CNT-1:0] eff_q, eff_d;

    logic [GADGET_BIT_CNT-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]             wr_q, rd_q;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic                      fifo_empty, fifo_full, push, pop;

`ifdef PLAT_FRAME_ACK_TIMEOUT_EN
    logic [7:0]                to_q, to_d;
`endif

    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == CW'(FIFO_DEPTH));

    // The head is popped while leaving DISPATCH, so a push landing in the
    // same cycle always sees the slot freed even when the queue was full.
    assign pop  = (state_q == S_DISP) && strobe_q && !i_game_start;
    assign push = i_gadget_valid && (!fifo_full || pop) && !i_game_start;

    always_comb begin
        cnt_d = cnt_q;
        if (i_game_start)
            cnt_d = '0;
        else
            cnt_d = cnt_q + CW'(push) - CW'(pop);
    end

    // Sequencer next state and next values of all registered outputs.
    always_comb begin
        state_d  = state_q;
        req_d    = 1'b0;
        strobe_d = 1'b0;
        done_d   = 1'b0;
        eff_d    = eff_q;
        err_d    = err_q;
`ifdef PLAT_FRAME_ACK_TIMEOUT_EN
        to_d     = to_q;
`endif
        if (i_game_start) begin
            state_d = S_IDLE;
            err_d   = '0;
            eff_d   = '0;
        end else begin
            if (i_gadget_valid && !push)
                err_d[0] = 1'b1;
            if (i_cal_frame && state_q != S_IDLE)
                err_d[1] = 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (i_cal_frame) begin
                        state_d = S_REQ;
                        req_d   = 1'b1;
`ifdef PLAT_FRAME_ACK_TIMEOUT_EN
                        to_d    = '0;
`endif
                    end
                end
                S_REQ: begin
                    if (i_plat_ack) begin
                        // req drops on the ack edge; the platform would
                        // toggle its ack if req stayed high.
                        state_d  = S_DISP;
                        done_d   = 1'b1;
                        strobe_d = !fifo_empty;
                        if (!fifo_empty)
                            eff_d = mem_q[rd_q];
`ifdef PLAT_FRAME_ACK_TIMEOUT_EN
                    end else if (to_q == 8'(ACK_TIMEOUT - 1)) begin
                        // Abandon: finish the frame without applying a gadget.
                        state_d  = S_DISP;
                        done_d   = 1'b1;
                        err_d[2] = 1'b1;
`endif
                    end else begin
                        req_d = 1'b1;
`ifdef PLAT_FRAME_ACK_TIMEOUT_EN
                        to_d  = to_q + 8'd1;
`endif
                    end
                end
                S_DISP:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            req_q    <= 1'b0;
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
            eff_q    <= '0;
            err_q    <= '0;
            busy_q   <= 1'b0;
            full_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            strobe_q <= strobe_d;
            done_q   <= done_d;
            eff_q    <= eff_d;
            err_q    <= err_d;
            busy_q   <= (state_d != S_IDLE);
            full_q   <= (cnt_d == CW'(FIFO_DEPTH));
        end
    end

`ifdef PLAT_FRAME_ACK_TIMEOUT_EN
    // Ack wait counter, restarted on every REQ entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) to_q <= '0;
        else        to_q <= to_d;
    end
`endif

    // Gadget FIFO storage and pointers; game start flushes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (i_game_start) begin
                wr_q <= '0;
                rd_q <= '0;
            end else begin
                if (push) begin
                    mem_q[wr_q] <= i_gadget_effect;
                    wr_q        <= wr_q + AW'(1);
                end
                if (pop)
                    rd_q <= rd_q + AW'(1);
            end
        end
    end

    assign o_plat_req            = req_q;
    assign o_plat_receive_gadget = strobe_q;
    assign o_plat_gadget_effect  = eff_q;
    assign o_frame_done          = done_q;
    assign o_busy                = busy_q;
    assign o_fifo_full           = full_q;
    assign o_err                 = err_q;

endmodule
